w0rm_peripheral_bus_mux_nport: RTL
==================================

Name: w0rm_peripheral_bus_mux_nport

Overview:
- Parametrised N-port response-return multiplexer for the W0RM memory and instruction buses.
- Replaces cascaded 2-port and 4-port extender trees with a single block.
- Adds behaviour the fixed-width extenders lack: selectable registered output, collision detection, stray-response detection, and a per-request watchdog.
- The watchdog returns an error word when no peripheral answers a CPU request, so the core never stalls on an unmapped address.

Parameters:
NUM_PORTS, 4, number of response ports (2..16).
DATA_WIDTH, 32, width of each response word (user bits included).
REGISTERED, 1, 1: response outputs registered (1-cycle latency); 0: combinational pass-through.
TIMEOUT_CYCLES, 16, response window in cycles after a request; 0 disables the watchdog.
ERROR_DATA, 32'hDEAD_BEEF (DATA_WIDTH wide), word returned on timeout.

Ports:
bus_clock  input  1  sole clock; all state updates on rising edge.
cpu_reset  input  1  synchronous, active-high reset.
bus_req_valid_i  input  1  master request strobe (CPU mem_valid_o / inst_valid_o); arms watchdog.
bus_port_valid_i  input  NUM_PORTS  per-port response valid; bit k = port k.
bus_port_data_i  input  NUM_PORTS*DATA_WIDTH  port k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
bus_valid_o  output  1  merged response valid.
bus_data_o  output  DATA_WIDTH  merged response data.
bus_timeout_o  output  1  one-cycle pulse, coincident with the ERROR_DATA response.
bus_collision_o  output  1  sticky: two or more port valids seen in one cycle.
bus_stray_o  output  1  sticky: response seen with no request outstanding.

Behaviour:
- Reset values: all outputs 0, state IDLE, watchdog counter 0. Reset wins over every other event, including mid-WAIT; a pending request is discarded without a timeout pulse.
- Selection: lowest-index asserted port wins. bus_data_o = that port's data; data is 0 when no port is valid.
- REGISTERED=1: a port response in cycle n appears on bus_valid_o/bus_data_o in cycle n+1.
- REGISTERED=0: port responses appear in the same cycle. Timeout responses are always registered.
- Collision: popcount(bus_port_valid_i) >= 2 sets bus_collision_o from the next cycle until reset. The winner is still forwarded; other ports are dropped.
- Watchdog FSM, states IDLE and WAIT:
  - IDLE, req=1, no response same cycle -> WAIT, cnt=0.
  - IDLE, req=1 with a response in the same cycle -> request complete; stay IDLE.
  - IDLE, response with req=0 -> forwarded; bus_stray_o set (sticky).
  - WAIT, response -> forwarded, state IDLE. If req=1 in the same cycle -> stay WAIT, cnt=0.
  - WAIT, req=1 without response -> cnt=0, stay WAIT. Restart; only one request outstanding at a time.
  - WAIT, no req, no response, cnt < TIMEOUT_CYCLES-1 -> cnt+1.
  - WAIT, no req, no response, cnt == TIMEOUT_CYCLES-1 -> next cycle: bus_valid_o=1, bus_data_o=ERROR_DATA, bus_timeout_o=1 for exactly one cycle; state IDLE.
- Net timing: request in cycle 0, response window is cycles 1..T. With no response, the timeout response appears in cycle T+1. A response in cycle T still wins; no timeout.
- Counter width: clog2(TIMEOUT_CYCLES+1); no wrap is possible.
- TIMEOUT_CYCLES=0: FSM held in IDLE; bus_timeout_o stays 0; bus_stray_o never sets.
- Timeout and a registered port response never coincide on the outputs. The response that would clash arrives in cycle T+1 or later, is treated as stray, and is forwarded one cycle after the timeout (REGISTERED=1).

Test Plan:
- Reset: hold cpu_reset 3 cycles with all port valids high -> all outputs 0. After release, port2 valid with data 0x1234 -> REGISTERED=1: bus_valid_o=1 with data 0x1234 one cycle later; bus_stray_o=1.
- Normal read, NUM_PORTS=4, T=16: req in cycle 0, port1 valid with 0xA5A5_0001 in cycle 3 -> output in cycle 4; bus_timeout_o never asserted; FSM IDLE.
- Timeout, T=4: req in cycle 0, no response -> cycle 5: bus_valid_o=1, data 0xDEAD_BEEF, bus_timeout_o=1 for one cycle only. Variant with port0 response in cycle 4 -> no timeout.
- Collision: ports 1 and 3 valid together with 0x11 and 0x33 -> output 0x11; bus_collision_o=1 from the next cycle and still 1 after 100 idle cycles; cleared only by reset.
- Restart and reset mid-WAIT, T=4: req in cycles 0 and 3 -> timeout in cycle 8. Separately, req in cycle 0 and reset in cycle 2 -> no timeout pulse ever.
- REGISTERED=0, NUM_PORTS=8: port7 valid with 0xFFFF_0007 -> same-cycle output. TIMEOUT_CYCLES=0 with req and no response for 100 cycles -> no output activity.

Source files
------------

// File: rtl/w0rm_peripheral_bus_mux_nport.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : w0rm_peripheral_bus_mux_nport                                     |
// | Brief  : N-port response-return mux with request watchdog, collision and   |
// |          stray-response flags for the W0RM memory/instruction buses.       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module w0rm_peripheral_bus_mux_nport #(
    parameter int                    NUM_PORTS      = 4,
    parameter int                    DATA_WIDTH     = 32,
    parameter bit                    REGISTERED     = 1'b1,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                            bus_clock,
    input  logic                            cpu_reset,
    input  logic                            bus_req_valid_i,
    input  logic [NUM_PORTS-1:0]            bus_port_valid_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] bus_port_data_i,
    output logic                            bus_valid_o,
    output logic [DATA_WIDTH-1:0]           bus_data_o,
    output logic                            bus_timeout_o,
    output logic                            bus_collision_o,
    output logic                            bus_stray_o
);

    localparam bit              c_WDOG_EN  = (TIMEOUT_CYCLES > 0);
    localparam int              c_CNT_W    = c_WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [0:0]      c_ST_IDLE  = 1'b0;
    localparam logic [0:0]      c_ST_WAIT  = 1'b1;

    logic                  w_any;
    logic                  w_multi;
    logic                  w_fire;
    logic [DATA_WIDTH-1:0] w_sel_data;

    logic [0:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_timeout;
    logic                  r_collision;
    logic                  r_stray;

    // Scan high-to-low so the lowest-index valid port is the last assignment.
    always_comb begin
        w_sel_data = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (bus_port_valid_i[k]) begin
                w_sel_data = bus_port_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_any   = |bus_port_valid_i;
    assign w_multi = |(bus_port_valid_i & (bus_port_valid_i - NUM_PORTS'(1)));
    assign w_fire  = c_WDOG_EN && (r_state == c_ST_WAIT) && !bus_req_valid_i &&
                     !w_any && (r_cnt == c_CNT_LAST);

    always_ff @(posedge bus_clock) begin
        if (cpu_reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
            r_collision <= 1'b0;
            r_stray     <= 1'b0;
        end else begin
            r_timeout <= w_fire;
            if (w_multi) begin
                r_collision <= 1'b1;
            end
            if (c_WDOG_EN) begin
                if (r_state == c_ST_IDLE) begin
                    if (bus_req_valid_i && !w_any) begin
                        r_state <= c_ST_WAIT;
                        r_cnt   <= '0;
                    end else if (w_any && !bus_req_valid_i) begin
                        r_stray <= 1'b1;
                    end
                end else begin
                    // A new request restarts the window even if a response lands now.
                    if (bus_req_valid_i) begin
                        r_cnt <= '0;
                    end else if (w_any || (r_cnt == c_CNT_LAST)) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus_collision_o = r_collision;
    assign bus_stray_o     = r_stray;

    generate
        if (REGISTERED) begin : g_reg_out
            logic                  r_valid;
            logic [DATA_WIDTH-1:0] r_data;

            always_ff @(posedge bus_clock) begin
                if (cpu_reset) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= w_any | w_fire;
                    r_data  <= w_any ? w_sel_data : (w_fire ? ERROR_DATA : '0);
                end
            end

            assign bus_valid_o   = r_valid;
            assign bus_data_o    = r_data;
            assign bus_timeout_o = r_timeout;
        end else begin : g_comb_out
            // The registered error word owns the output in its cycle; a
            // simultaneous port response is late by definition and is dropped.
            assign bus_valid_o   = !cpu_reset && (w_any || r_timeout);
            assign bus_data_o    = cpu_reset ? '0 : (r_timeout ? ERROR_DATA : w_sel_data);
            assign bus_timeout_o = !cpu_reset && r_timeout;
        end
    endgenerate

endmodule
`default_nettype wire
